dcache_wt: RTL

Parametrised direct-mapped, write-through, no-write-allocate data cache between the MEM stage and the shared RAM port. It adds configurable line count, a multi-entry write buffer FIFO with per-byte strobes, a registered RAM handshake FSM and a whole-cache flush. Stalls the pipeline through `stallreq` only on read miss or a full write buffer.

---
 rtl/dcache_wt_pkg.sv | 35 +++
 rtl/dcache_wt_wbuf.sv | 61 ++++++
 rtl/dcache_wt.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dcache_wt_pkg.sv
// Shared types and constants for the write-through data cache.
package dcache_wt_pkg;

   localparam logic        RstEnable   = 1'b1;
   localparam logic        ChipEnable  = 1'b1;
   localparam logic        WriteEnable = 1'b1;
   localparam logic [31:0] ZeroWord    = 32'h0000_0000;

   // Write-buffer entry: word address, store data, byte strobes.
   localparam int WB_ENTRY_W = 66;

   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  sel;
   } wb_entry_t;

   typedef enum logic [1:0] {
      CacheIdle   = 2'd0,
      CacheWrite  = 2'd1,
      CacheRefill = 2'd2
   } cache_state_e;

   // Replace only the strobed bytes of old_w with the matching bytes of new_w.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  sel);
      logic [31:0] merged;
      for (int b = 0; b < 4; b++) begin
         merged[b*8 +: 8] = sel[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dcache_wt_wbuf.sv
// Store write buffer: synchronous FIFO with a combinational head read.
// Push while full and pop while empty are ignored, so callers need not gate them.
module dcache_wbuf #(
   parameter int WB_DEPTH = 4,
   parameter int W        = 66
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_din,
   input  logic         i_pop,
   output logic [W-1:0] o_head,
   output logic         o_full,
   output logic         o_empty
);

   localparam int PTR_W = $clog2(WB_DEPTH);

   logic [W-1:0]     r_mem [WB_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic w_push_ok;
   logic w_pop_ok;

   assign o_full    = (r_count == (PTR_W+1)'(WB_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rd_ptr];
   assign w_push_ok = i_push & ~o_full;
   assign w_pop_ok  = i_pop & ~o_empty;

   // Entry storage; contents need no reset because the count gates them.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
            2'b01:   r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   CacheIdle   | no RAM request; pick drain (priority) or refill
//   CacheWrite  | RAM write of the write-buffer head, pop on ram_data_ready
//   CacheRefill | RAM read of the missing line, fill on ram_data_ready
//
// RAM outputs are registered alongside the state so a request is stable
// from its first cycle until the RAM accepts it.
module dcache_wt
   import dcache_wt_pkg::*;
#(
   parameter int LINES    = 16,
   parameter int WB_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic        flush_i,
   output logic [31:0] mem_data_o,
   output logic        stallreq,
   output logic        ram_ce_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   input  logic        ram_data_ready
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - IDX_W;

   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag  [LINES];
   logic [31:0]      r_data [LINES];

   cache_state_e r_state;
   logic         r_ram_ce;
   logic         r_ram_we;
   logic [3:0]   r_ram_sel;
   logic [31:0]  r_ram_addr;
   logic [31:0]  r_ram_data;

   logic [IDX_W-1:0] w_idx;
   logic [TAG_W-1:0] w_tag;
   logic [IDX_W-1:0] w_fill_idx;
   logic [TAG_W-1:0] w_fill_tag;
   logic             w_hit;
   logic             w_load_hit;
   logic             w_load_miss;
   logic             w_store;
   logic             w_push;
   logic             w_pop;
   logic             w_refill_done;
   logic             w_full;
   logic             w_empty;
   wb_entry_t        w_push_entry;
   wb_entry_t        w_head;
   wb_entry_t        w_wr_src;
   logic             w_unused_ok;

   // Byte offset of the address never selects anything in a word cache.
   assign w_unused_ok = ^mem_addr_i[1:0];

   assign w_idx       = mem_addr_i[IDX_W+1:2];
   assign w_tag       = mem_addr_i[31:IDX_W+2];
   assign w_fill_idx  = r_ram_addr[IDX_W+1:2];
   assign w_fill_tag  = r_ram_addr[31:IDX_W+2];

   assign w_hit       = mem_ce_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_load_hit  = w_hit & ~mem_we_i;
   assign w_load_miss = mem_ce_i & ~mem_we_i & ~w_hit;
   assign w_store     = mem_ce_i & mem_we_i;

   // A full buffer blocks the store even when a pop lands on the same edge.
   assign w_push        = w_store & ~w_full & (rst != RstEnable);
   assign w_pop         = (r_state == CacheWrite) & ram_data_ready;
   assign w_refill_done = (r_state == CacheRefill) & ram_data_ready;

   assign w_push_entry = '{addr: mem_addr_i[31:2], data: mem_data_i, sel: mem_sel_i};
   // An empty buffer means the store being pushed now is the one to write.
   assign w_wr_src     = w_empty ? w_push_entry : w_head;

   assign stallreq   = (rst != RstEnable) &
                       (w_load_miss | (w_store & w_full));
   assign mem_data_o = ((rst == RstEnable) || !w_load_hit) ? ZeroWord : r_data[w_idx];

   assign ram_ce_o   = r_ram_ce;
   assign ram_we_o   = r_ram_we;
   assign ram_sel_o  = r_ram_sel;
   assign ram_addr_o = r_ram_addr;
   assign ram_data_o = r_ram_data;

   dcache_wbuf #(
      .WB_DEPTH (WB_DEPTH),
      .W        (WB_ENTRY_W)
   ) u_wbuf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_din   (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Valid bits: flush clears every line in one edge and beats a same-edge fill.
   always_ff @(posedge clk) begin
      if (rst == RstEnable || flush_i) begin
         r_valid <= '0;
      end else if (w_refill_done) begin
         r_valid[w_fill_idx] <= 1'b1;
      end
   end

   // Tag/data arrays: refill writes a whole line, a store hit merges bytes.
   always_ff @(posedge clk) begin
      if (w_refill_done) begin
         r_tag[w_fill_idx]  <= w_fill_tag;
         r_data[w_fill_idx] <= ram_data_i;
      end else if (w_push && w_hit) begin
         r_data[w_idx] <= byte_merge(r_data[w_idx], mem_data_i, mem_sel_i);
      end
   end

   // RAM handshake FSM with registered request outputs.
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         r_state    <= CacheIdle;
         r_ram_ce   <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_sel  <= 4'b0000;
         r_ram_addr <= ZeroWord;
         r_ram_data <= ZeroWord;
      end else begin
         case (r_state)
            CacheIdle: begin
               if (!w_empty || w_push) begin
                  r_state    <= CacheWrite;
                  r_ram_ce   <= ChipEnable;
                  r_ram_we   <= WriteEnable;
                  r_ram_sel  <= w_wr_src.sel;
                  r_ram_addr <= {w_wr_src.addr, 2'b00};
                  r_ram_data <= w_wr_src.data;
               end else if (w_load_miss) begin
                  r_state    <= CacheRefill;
                  r_ram_ce   <= ChipEnable;
                  r_ram_we   <= ~WriteEnable;
                  r_ram_sel  <= 4'b1111;
                  r_ram_addr <= {mem_addr_i[31:2], 2'b00};
                  r_ram_data <= ZeroWord;
               end
            end
            CacheWrite, CacheRefill: begin
               if (ram_data_ready) begin
                  r_state    <= CacheIdle;
                  r_ram_ce   <= 1'b0;
                  r_ram_we   <= 1'b0;
                  r_ram_sel  <= 4'b0000;
                  r_ram_addr <= ZeroWord;
                  r_ram_data <= ZeroWord;
               end
            end
            default: begin
               r_state    <= CacheIdle;
               r_ram_ce   <= 1'b0;
               r_ram_we   <= 1'b0;
               r_ram_sel  <= 4'b0000;
               r_ram_addr <= ZeroWord;
               r_ram_data <= ZeroWord;
            end
         endcase
      end
   end

endmodule
